// File: rtl/denise_bitplane_shifter.sv
// rtl/denise_bitplane_shifter.sv - bitplane data latches, scroll-delayed load sequencers and pixel shifters
module denise_bitplane_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic        clk7n_en,
    input  logic        ecs,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [8:1]  bpldata
);

    localparam logic [8:1] BPLCON0  = 8'h80;
    localparam logic [8:1] BPLCON1  = 8'h81;
    localparam logic [8:1] BPL1DAT  = 8'h88;

    logic       hires;
    logic       shres;
    logic [3:0] pf1h;
    logic [3:0] pf2h;

    logic [3:0] pf1_cnt;
    logic [3:0] pf2_cnt;
    logic       pf1_pend;
    logic       pf2_pend;

    logic bpl1_wr;
    logic pf1_load;
    logic pf2_load;
    logic shift_en;

    assign bpl1_wr = clk7_en && (reg_address_in == BPL1DAT);

    // A fresh BPL1DAT write always wins over a load that was about to happen.
    assign pf1_load = clk7_en && pf1_pend && (pf1_cnt == 4'd0) && !bpl1_wr;
    assign pf2_load = clk7_en && pf2_pend && (pf2_cnt == 4'd0) && !bpl1_wr;

    assign shift_en = shres ? 1'b1 :
                      hires ? (clk7_en | clk7n_en) :
                              clk7_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hires <= 1'b0;
            shres <= 1'b0;
            pf1h  <= 4'd0;
            pf2h  <= 4'd0;
        end else if (clk7_en) begin
            if (reg_address_in == BPLCON0) begin
                hires <= data_in[15];
                shres <= data_in[6] & ecs;
            end
            if (reg_address_in == BPLCON1) begin
                pf1h <= data_in[3:0];
                pf2h <= data_in[7:4];
            end
        end
    end

    // Scroll delay is counted in clk7_en periods regardless of pixel rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf1_cnt  <= 4'd0;
            pf2_cnt  <= 4'd0;
            pf1_pend <= 1'b0;
            pf2_pend <= 1'b0;
        end else if (bpl1_wr) begin
            pf1_cnt  <= pf1h;
            pf2_cnt  <= pf2h;
            pf1_pend <= 1'b1;
            pf2_pend <= 1'b1;
        end else if (clk7_en) begin
            if (pf1_pend) begin
                if (pf1_cnt != 4'd0)
                    pf1_cnt <= pf1_cnt - 4'd1;
                else
                    pf1_pend <= 1'b0;
            end
            if (pf2_pend) begin
                if (pf2_cnt != 4'd0)
                    pf2_cnt <= pf2_cnt - 4'd1;
                else
                    pf2_pend <= 1'b0;
            end
        end
    end

    for (genvar n = 1; n <= 8; n++) begin : g_plane
        logic [15:0] latch;
        logic [15:0] sh;
        logic        load;

        // Odd planes belong to playfield 1, even planes to playfield 2.
        assign load = (n % 2 == 1) ? pf1_load : pf2_load;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                latch <= 16'd0;
                sh    <= 16'd0;
            end else begin
                if (clk7_en && (reg_address_in == BPL1DAT + 8'(n - 1)))
                    latch <= data_in;
                if (load)
                    sh <= latch;
                else if (shift_en)
                    sh <= {sh[14:0], 1'b0};
            end
        end

        assign bpldata[n] = sh[15];
    end

endmodule

// File: tb/tb_denise_bitplane_shifter.sv
// tb/tb_denise_bitplane_shifter.sv - directed self-checking bench for denise_bitplane_shifter
module tb_denise_bitplane_shifter;

    localparam logic [7:0] A_BPLCON0 = 8'h80;
    localparam logic [7:0] A_BPLCON1 = 8'h81;
    localparam logic [7:0] A_BPL1DAT = 8'h88;
    localparam logic [7:0] A_BPL2DAT = 8'h89;
    localparam logic [7:0] A_BPL3DAT = 8'h8A;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk7_en;
    logic        clk7n_en;
    logic        ecs;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic [8:1]  bpldata;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [1:0]  phase  = 2'd0;

    denise_bitplane_shifter dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .clk7n_en       (clk7n_en),
        .ecs            (ecs),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .bpldata        (bpldata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        clk7_en  = (phase == 2'd0);
        clk7n_en = (phase == 2'd2);
        @(posedge clk);
        #1;
        phase = phase + 2'd1;
    endtask

    task automatic to_c7_edge();
        while (phase != 2'd0) tick();
        tick();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] data);
        while (phase != 2'd0) tick();
        reg_address_in = addr;
        data_in        = data;
        tick();
        reg_address_in = 8'h00;
        data_in        = 16'h0000;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset          = 1'b1;
        ecs            = 1'b0;
        clk7_en        = 1'b0;
        clk7n_en       = 1'b0;
        reg_address_in = 8'h00;
        data_in        = 16'h0000;
        repeat (4) tick();
        chk("reset_state", 16'(bpldata), 16'h00);
        reset = 1'b0;

        // reset while plane 1 is mid-shift
        wr(A_BPL1DAT, 16'hFFFF);
        to_c7_edge();
        chk("pre_reset_loaded", 16'(bpldata[1]), 16'h1);
        #2 reset = 1'b1;
        #1 chk("async_reset", 16'(bpldata), 16'h00);
        repeat (3) tick();
        reset = 1'b0;
        for (int e = 0; e < 20; e++) begin
            to_c7_edge();
            chk("idle_after_reset", 16'(bpldata), 16'h00);
        end

        // lores, no scroll
        wr(A_BPL2DAT, 16'h0000);
        wr(A_BPL1DAT, 16'h8001);
        chk("lores_before_load", 16'(bpldata[1]), 16'h0);
        to_c7_edge();
        chk("lores_px1", 16'(bpldata[1]), 16'h1);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("lores_px1_hold", 16'(bpldata[1]), 16'h1);
        end
        for (int p = 2; p <= 15; p++) begin
            to_c7_edge();
            chk("lores_mid", 16'(bpldata[1]), 16'h0);
        end
        to_c7_edge();
        chk("lores_px16", 16'(bpldata[1]), 16'h1);
        to_c7_edge();
        chk("lores_drained", 16'(bpldata[1]), 16'h0);

        // split scroll: pf1h = 0, pf2h = 3
        wr(A_BPLCON1, 16'h0030);
        wr(A_BPL2DAT, 16'h8000);
        wr(A_BPL1DAT, 16'h8000);
        chk("split_n", 16'(bpldata[2:1]), 16'h0);
        to_c7_edge();
        chk("split_n1", 16'(bpldata[2:1]), 16'h1);
        to_c7_edge();
        chk("split_n2", 16'(bpldata[2:1]), 16'h0);
        to_c7_edge();
        chk("split_n3", 16'(bpldata[2:1]), 16'h0);
        to_c7_edge();
        chk("split_n4", 16'(bpldata[2:1]), 16'h2);

        // hires rate
        wr(A_BPLCON1, 16'h0000);
        wr(A_BPLCON0, 16'h8000);
        wr(A_BPL1DAT, 16'hAAAA);
        to_c7_edge();
        chk("hires_load", 16'(bpldata[1]), 16'h1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("hires_rate", 16'(bpldata[1]), 16'(((j / 2) % 2) == 0));
        end

        // shres rate with ecs
        ecs = 1'b1;
        wr(A_BPLCON0, 16'h0040);
        wr(A_BPL1DAT, 16'hAAAA);
        to_c7_edge();
        chk("shres_load", 16'(bpldata[1]), 16'h1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("shres_rate", 16'(bpldata[1]), 16'((j % 2) == 0));
        end

        // shres bit ignored without ecs
        ecs = 1'b0;
        wr(A_BPLCON0, 16'h0040);
        wr(A_BPL1DAT, 16'hAAAA);
        to_c7_edge();
        chk("noecs_load", 16'(bpldata[1]), 16'h1);
        for (int j = 1; j <= 8; j++) begin
            tick();
            chk("noecs_rate", 16'(bpldata[1]), 16'(((j / 4) % 2) == 0));
        end

        // re-arm: pf1h = 5, second write two edges later
        wr(A_BPLCON0, 16'h0000);
        wr(A_BPLCON1, 16'h0005);
        for (int e = 0; e < 16; e++) to_c7_edge();
        chk("rearm_drained", 16'(bpldata), 16'h00);
        wr(A_BPL1DAT, 16'hF000);
        to_c7_edge();
        wr(A_BPL1DAT, 16'h0F00);
        for (int e = 3; e <= 16; e++) begin
            to_c7_edge();
            chk("rearm", 16'(bpldata[1]), 16'((e >= 12) && (e <= 15)));
        end

        // load/shift collision in shres
        wr(A_BPLCON1, 16'h0000);
        ecs = 1'b1;
        wr(A_BPLCON0, 16'h0040);
        wr(A_BPL1DAT, 16'hFFFF);
        to_c7_edge();
        wr(A_BPL1DAT, 16'h8001);
        to_c7_edge();
        chk("collide_load", 16'(bpldata[1]), 16'h1);
        for (int j = 1; j <= 16; j++) begin
            tick();
            chk("collide_shift", 16'(bpldata[1]), 16'(j == 15));
        end

        // BPL3DAT write on the load edge is not captured by that load
        ecs = 1'b0;
        wr(A_BPLCON0, 16'h0000);
        wr(A_BPL3DAT, 16'h8000);
        wr(A_BPL1DAT, 16'h0000);
        wr(A_BPL3DAT, 16'h4000);
        chk("latch_old_load", 16'(bpldata[3]), 16'h1);
        to_c7_edge();
        chk("latch_old_shift", 16'(bpldata[3]), 16'h0);
        wr(A_BPL1DAT, 16'h0000);
        to_c7_edge();
        chk("latch_new_load", 16'(bpldata[3]), 16'h0);
        to_c7_edge();
        chk("latch_new_shift", 16'(bpldata[3]), 16'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/denise_bitplane_shifter.md
# denise_bitplane_shifter

Display-side consumer of the bitplane DMA engine: captures the BPL1DAT..BPL8DAT words that the DMA engine writes onto the register bus and turns them into a per-pixel plane-bit vector for the playfield priority and colour logic. It applies the BPLCON1 horizontal scroll delay independently to the odd and even planes. It shifts at lores, hires or shres pixel rate according to BPLCON0.

## Interface
Parameters: none.

- clk  in  1  28 MHz bus clock.
- reset  in  1  Asynchronous, active-high. One clock; reset is asynchronous and active-high.
- clk7_en  in  1  7 MHz strobe, one clk in four. This is the lores pixel rate and the register-write sample point.
- clk7n_en  in  1  7 MHz strobe two clks after clk7_en. ORed with clk7_en, it gives the hires rate.
- ecs  in  1  Enables the SHRES bit.
- reg_address_in  in  8 [8:1]  Register bus word address.
- data_in  in  16  Register bus data.
- bpldata  out  8 [8:1]  Current pixel bit of each plane: bit n is plane n.

## Operation
- Register decode happens only on clk7_en edges. The word addresses are:
  - BPLCON0 = 8'h80: hires ← data_in[15]; shres ← data_in[6] & ecs.
  - BPLCON1 = 8'h81: pf1h ← data_in[3:0] (odd planes); pf2h ← data_in[7:4] (even planes).
  - BPLnDAT = 8'h88+(n-1), for n = 1..8: latch[n] ← data_in.
- Writing BPL1DAT also arms both playfield load sequencers. Each sequencer is a 4-bit delay counter plus a pending flag. The counter is loaded with pf1h or pf2h respectively, using the BPLCON1 value in effect before that edge.
- On each later clk7_en edge where a sequencer is pending:
  - counter ≠ 0: decrement.
  - counter = 0: parallel-load that sequencer's planes from the latches and clear pending. Playfield 1 loads shifter[1,3,5,7]; playfield 2 loads shifter[2,4,6,8]. Latch contents are sampled at the load edge, so a BPLxDAT write landing on the load edge is not included.
- If BPL1DAT is rewritten while a sequencer is pending, that sequencer re-arms: the counter reloads and pending stays set. The earlier load is discarded.
- There are eight 16-bit shifters. Each shift moves left by one and inserts 0 at bit 0. bpldata[n] = shifter[n][15], driven straight from the register.
- Shift enable is evaluated on every clk:
  - shres = 1: every clk.
  - else hires = 1: clk7_en | clk7n_en.
  - else: clk7_en.
  - shres takes priority over hires.
- When a parallel load and a shift fall on the same edge for a shifter, the load wins and no shift happens that edge.
- Scroll is counted in lores pixels (clk7_en periods) in every mode.

## Timing
- Reset state:
  - all latches, shifters and bpldata = 0.
  - hires = shres = 0; pf1h = pf2h = 0.
  - both sequencers idle with counters = 0.
- A register write is captured at the clk7_en edge where the address is valid, and takes effect from the next clk.
- A BPL1DAT write at clk7_en edge N with scroll s loads the shifters at clk7_en edge N+1+s. bpldata shows bit 15 from that edge onward.
- Pixel hold times after the load:
  - lores: one bit per 4 clks, 16 bits span 64 clks.
  - hires: one bit per 2 clks.
  - shres: one bit per clk.
- A BPLCON0 mode change alters the shift rate from the clk after the write edge. Shifter contents are untouched.
- When a shifter has been fully shifted out and no new load arrives, bpldata[n] = 0.
- A reset assertion mid-sequence immediately clears all state, with no clock needed. After deassertion, no load happens until a new BPL1DAT write.
- Planes 7 and 8 follow exactly the same behaviour as the other planes. Whether they are used is decided downstream.

## Test plan
- Reset and idle:
  - Stimulus: assert reset mid-shift with shifter[1] = 16'hFFFF.
  - Required: bpldata = 8'h00 immediately, and it stays 0 after deassertion with no writes.
- Lores, no scroll:
  - Stimulus: BPL2DAT = 16'h0000, then BPL1DAT = 16'h8001 at edge N.
  - Required: bpldata[1] = 1 for clks [N+1, N+2) in clk7_en units, 0 for the next 14 pixels, 1 for the 16th pixel. Each pixel lasts 4 clks.
- Split scroll:
  - Stimulus: BPLCON1 = 16'h0030 (pf1h = 0, pf2h = 3), BPL2DAT = 16'h8000, BPL1DAT = 16'h8000 at edge N.
  - Required: bpldata[1] rises at clk7_en edge N+1; bpldata[2] rises at edge N+4.
- Hires and shres rates:
  - Stimulus: BPL1DAT = 16'hAAAA in hires, then again in shres (with ecs = 1).
  - Required: bpldata[1] toggles every 2 clks in hires and every clk in shres.
  - Repeat with ecs = 0 and BPLCON0 bit 6 set: the output must run at the lores rate.
- Re-arm:
  - Stimulus: pf1h = 5; BPL1DAT = 16'hF000 at edge N, then BPL1DAT = 16'h0F00 at edge N+2.
  - Required: no load at N+6; a single load of 16'h0F00 at N+8.
- Load/shift collision:
  - Stimulus: in shres, a load edge while shifter[1] still holds data.
  - Required: the new word appears intact and is not shifted on the load edge.
  - Stimulus: a BPL3DAT write on the load edge.
  - Required: the old latch value is loaded, and the new value appears at the following load.
